// File: rtl/pulse_train_pkg.sv
// Shared state type, default sizing and phase-length helper for the pulse train generator.
package pulse_train_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ACTIVE,
        GAP
    } statetype;

    localparam int DEF_MAX_DELAY   = 10000000;
    localparam int DEF_MAX_PULSE   = 1024;
    localparam int DEF_MAX_WIDTH   = 65536;
    localparam int DEF_DELAY_WIDTH = $clog2(DEF_MAX_DELAY);
    localparam int DEF_PULSE_WIDTH = $clog2(DEF_MAX_PULSE + 1);
    localparam int DEF_WIDTH_WIDTH = $clog2(DEF_MAX_WIDTH);

    localparam int SYNC_STAGES = 2;

    // A programmed width of 0 behaves as 1, so a W-cycle phase ends when its down-counter reaches max(W,1)-1 steps.
    function automatic int unsigned phase_last_count(input int unsigned width);
        return (width == 0) ? 0 : width - 1;
    endfunction

endpackage

// File: rtl/pulse_train_generator_trigger_synchronizer.sv
// Trigger synchronizer (SYNC_STAGES flops) with registered rising-edge detect.
// Only compiled when TRIGGER_SYNC_EN is defined.
`ifdef TRIGGER_SYNC_EN
module trigger_synchronizer
    import pulse_train_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_last  <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_last  <= r_sync[SYNC_STAGES-1];
            o_pulse <= r_sync[SYNC_STAGES-1] & ~r_last;
        end
    end

endmodule
`endif

// File: rtl/pulse_train_generator.sv
// Pulse train transmitter: after a programmable delay emits N pulses of width H separated by gaps of width L.
// Build option TRIGGER_SYNC_EN: trigger is synchronized and edge-detected instead of sampled as a level.
module pulse_train_generator
    import pulse_train_pkg::*;
#(
    parameter int MAX_DELAY   = DEF_MAX_DELAY,
    parameter int MAX_PULSE   = DEF_MAX_PULSE,
    parameter int MAX_WIDTH   = DEF_MAX_WIDTH,
    parameter int DELAY_WIDTH = $clog2(MAX_DELAY),
    parameter int PULSE_WIDTH = $clog2(MAX_PULSE + 1),
    parameter int WIDTH_WIDTH = $clog2(MAX_WIDTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_auto_start,
    input  logic                   i_trigger,
    input  logic                   i_abort,
    input  logic [DELAY_WIDTH-1:0] i_delay_value,
    input  logic                   i_delay_set,
    input  logic [PULSE_WIDTH-1:0] i_count_value,
    input  logic                   i_count_set,
    input  logic [WIDTH_WIDTH-1:0] i_high_value,
    input  logic [WIDTH_WIDTH-1:0] i_low_value,
    input  logic                   i_width_set,
    input  logic                   i_polarity_value,
    input  logic                   i_polarity_set,
    output logic                   o_output_signal,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [PULSE_WIDTH-1:0] o_pulses_sent
);

    localparam int CNT_WIDTH = (DELAY_WIDTH > WIDTH_WIDTH) ? DELAY_WIDTH : WIDTH_WIDTH;

    logic [DELAY_WIDTH-1:0] r_cfg_delay;
    logic [PULSE_WIDTH-1:0] r_cfg_count;
    logic [WIDTH_WIDTH-1:0] r_cfg_high;
    logic [WIDTH_WIDTH-1:0] r_cfg_low;
    logic                   r_cfg_pol;

    logic [PULSE_WIDTH-1:0] r_n;
    logic [WIDTH_WIDTH-1:0] r_high;
    logic [WIDTH_WIDTH-1:0] r_low;
    logic                   r_pol;

    statetype               r_state;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [PULSE_WIDTH-1:0] r_sent;
    logic                   r_out;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_trigger;
    logic [PULSE_WIDTH-1:0] w_sent_next;
    logic [CNT_WIDTH-1:0]   w_high_load;
    logic [CNT_WIDTH-1:0]   w_low_load;

`ifdef TRIGGER_SYNC_EN
    trigger_synchronizer u_trigger_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_trigger),
        .o_pulse (w_trigger)
    );
`else
    assign w_trigger = i_trigger;
`endif

    assign w_sent_next = r_sent + PULSE_WIDTH'(1);
    assign w_high_load = CNT_WIDTH'(phase_last_count(32'(r_high)));
    assign w_low_load  = CNT_WIDTH'(phase_last_count(32'(r_low)));

    // The acceptance edge always spends one cycle before ACTIVE so the first pulse lands D+1 edges after the trigger.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg_delay <= '0;
            r_cfg_count <= '0;
            r_cfg_high  <= '0;
            r_cfg_low   <= '0;
            r_cfg_pol   <= 1'b0;
            r_n         <= '0;
            r_high      <= '0;
            r_low       <= '0;
            r_pol       <= 1'b0;
            r_state     <= IDLE;
            r_count     <= '0;
            r_sent      <= '0;
            r_out       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (i_delay_set) begin
                r_cfg_delay <= i_delay_value;
            end
            if (i_count_set) begin
                r_cfg_count <= i_count_value;
            end
            if (i_width_set) begin
                r_cfg_high <= i_high_value;
                r_cfg_low  <= i_low_value;
            end
            if (i_polarity_set) begin
                r_cfg_pol <= i_polarity_value;
            end

            r_done <= 1'b0;

            if (i_abort) begin
                r_state <= IDLE;
                r_out   <= r_pol;
                r_busy  <= 1'b0;
            end else if (i_auto_start) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_trigger) begin
                            r_n     <= r_cfg_count;
                            r_high  <= r_cfg_high;
                            r_low   <= r_cfg_low;
                            r_pol   <= r_cfg_pol;
                            r_count <= CNT_WIDTH'(r_cfg_delay);
                            r_sent  <= '0;
                            r_busy  <= 1'b1;
                            r_out   <= r_cfg_pol;
                            r_state <= DELAY;
                        end else begin
                            r_out <= i_polarity_set ? i_polarity_value : r_cfg_pol;
                        end
                    end
                    DELAY: begin
                        if (r_count != '0) begin
                            r_count <= r_count - CNT_WIDTH'(1);
                        end else if (r_n == '0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_out   <= ~r_pol;
                            r_count <= w_high_load;
                            r_state <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (r_count != '0) begin
                            r_count <= r_count - CNT_WIDTH'(1);
                        end else begin
                            r_sent <= w_sent_next;
                            r_out  <= r_pol;
                            if (w_sent_next == r_n) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_count <= w_low_load;
                                r_state <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        if (r_count != '0) begin
                            r_count <= r_count - CNT_WIDTH'(1);
                        end else begin
                            r_out   <= ~r_pol;
                            r_count <= w_high_load;
                            r_state <= ACTIVE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_output_signal = r_out;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pulses_sent   = r_sent;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator: directed scenarios plus random trains against a timeline model.
module tb_pulse_train_generator;
    import pulse_train_pkg::*;

    localparam int DW = DEF_DELAY_WIDTH;
    localparam int PW = DEF_PULSE_WIDTH;
    localparam int WW = DEF_WIDTH_WIDTH;

    typedef struct {
        bit out;
        bit busy;
        bit done;
        int sent;
    } ExpectedT;

    logic          clock = 1'b0;
    logic          resetN;
    logic          autoStart;
    logic          trigger;
    logic          abort;
    logic [DW-1:0] delayValue;
    logic          delaySet;
    logic [PW-1:0] countValue;
    logic          countSet;
    logic [WW-1:0] highValue;
    logic [WW-1:0] lowValue;
    logic          widthSet;
    logic          polarityValue;
    logic          polaritySet;
    logic          outputSignal;
    logic          busy;
    logic          done;
    logic [PW-1:0] pulsesSent;

    int checks = 0;
    int failures = 0;

    pulse_train_generator dut (
        .i_clk            (clock),
        .i_rst_n          (resetN),
        .i_auto_start     (autoStart),
        .i_trigger        (trigger),
        .i_abort          (abort),
        .i_delay_value    (delayValue),
        .i_delay_set      (delaySet),
        .i_count_value    (countValue),
        .i_count_set      (countSet),
        .i_high_value     (highValue),
        .i_low_value      (lowValue),
        .i_width_set      (widthSet),
        .i_polarity_value (polarityValue),
        .i_polarity_set   (polaritySet),
        .o_output_signal  (outputSignal),
        .o_busy           (busy),
        .o_done           (done),
        .o_pulses_sent    (pulsesSent)
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Train length in edges after acceptance: the edge on which done fires.
    function automatic int trainEnd(input int d, input int n, input int h, input int l);
        int hh;
        int ll;
        hh = (h == 0) ? 1 : h;
        ll = (l == 0) ? 1 : l;
        if (n == 0) return d + 1;
        return d + 1 + n * hh + (n - 1) * ll;
    endfunction

    // Expected outputs o edges after the trigger was accepted (o = 0 is the acceptance edge).
    function automatic ExpectedT model(input int d, input int n, input int h, input int l, input bit p, input int o);
        ExpectedT e;
        int hh;
        int ll;
        int r;
        int per;
        int endEdge;
        hh = (h == 0) ? 1 : h;
        ll = (l == 0) ? 1 : l;
        endEdge = trainEnd(d, n, h, l);
        e.out  = p;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.sent = 0;
        if (o >= endEdge) begin
            e.busy = 1'b0;
            e.done = (o == endEdge);
            e.sent = n;
        end else if (o > d) begin
            r   = o - (d + 1);
            per = hh + ll;
            e.sent = r / per;
            if ((r % per) < hh) e.out = ~p;
            else e.sent = e.sent + 1;
        end
        return e;
    endfunction

    task automatic checkCycle(input string name, input ExpectedT e);
        checkOutput($sformatf("%s.out", name), int'(outputSignal), int'(e.out));
        checkOutput($sformatf("%s.busy", name), int'(busy), int'(e.busy));
        checkOutput($sformatf("%s.done", name), int'(done), int'(e.done));
        checkOutput($sformatf("%s.sent", name), int'(pulsesSent), e.sent);
    endtask

    task automatic applyStimulus(input int d, input int n, input int h, input int l, input bit p);
        delayValue    = DW'(d);
        countValue    = PW'(n);
        highValue     = WW'(h);
        lowValue      = WW'(l);
        polarityValue = p;
        delaySet      = 1'b1;
        countSet      = 1'b1;
        widthSet      = 1'b1;
        polaritySet   = 1'b1;
        tick();
        delaySet    = 1'b0;
        countSet    = 1'b0;
        widthSet    = 1'b0;
        polaritySet = 1'b0;
        checkOutput("idleLevel", int'(outputSignal), int'(p));
        tick();
    endtask

    task automatic runTrain(input string label, input int d, input int n, input int h, input int l, input bit p,
                            input int midAt, input int midD, input int midN, input int freezeAt, input int abortAt);
        int o;
        int lastO;
        bit midPending;
        bit aborted;
        midPending = 1'b0;
        aborted    = 1'b0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        o = 0;
        checkCycle($sformatf("%s@%0d", label, o), model(d, n, h, l, p, o));
        lastO = trainEnd(d, n, h, l) + 1;
        while (o < lastO && !aborted) begin
            if (o == midAt) begin
                delayValue = DW'(midD);
                countValue = PW'(midN);
                delaySet   = 1'b1;
                countSet   = 1'b1;
                trigger    = 1'b1;
                midPending = 1'b1;
            end
            if (o == freezeAt) begin
                autoStart = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    tick();
                    checkCycle($sformatf("%s@%0d.frozen%0d", label, o, j), model(d, n, h, l, p, o));
                end
                autoStart = 1'b1;
            end
            if (o == abortAt) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                checkOutput($sformatf("%s.abort.out", label), int'(outputSignal), int'(p));
                checkOutput($sformatf("%s.abort.busy", label), int'(busy), 0);
                checkOutput($sformatf("%s.abort.done", label), int'(done), 0);
                checkOutput($sformatf("%s.abort.sent", label), int'(pulsesSent), model(d, n, h, l, p, o).sent);
                tick();
                checkOutput($sformatf("%s.afterAbort.done", label), int'(done), 0);
                checkOutput($sformatf("%s.afterAbort.busy", label), int'(busy), 0);
                checkOutput($sformatf("%s.afterAbort.out", label), int'(outputSignal), int'(p));
                aborted = 1'b1;
            end else begin
                tick();
                if (midPending) begin
                    delaySet   = 1'b0;
                    countSet   = 1'b0;
                    trigger    = 1'b0;
                    midPending = 1'b0;
                end
                o++;
                checkCycle($sformatf("%s@%0d", label, o), model(d, n, h, l, p, o));
            end
        end
    endtask

    initial begin
        int d;
        int n;
        int h;
        int l;
        bit p;
        int endA;
        int endB;
        resetN        = 1'b0;
        autoStart     = 1'b0;
        trigger       = 1'b0;
        abort         = 1'b0;
        delayValue    = '0;
        delaySet      = 1'b0;
        countValue    = '0;
        countSet      = 1'b0;
        highValue     = '0;
        lowValue      = '0;
        widthSet      = 1'b0;
        polarityValue = 1'b0;
        polaritySet   = 1'b0;

        #12;
        checkOutput("reset.out", int'(outputSignal), 0);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.done", int'(done), 0);
        checkOutput("reset.sent", int'(pulsesSent), 0);
        resetN    = 1'b1;
        autoStart = 1'b1;
        tick();

        applyStimulus(5, 3, 2, 3, 1'b0);
        runTrain("basic", 5, 3, 2, 3, 1'b0, -1, 0, 0, -1, -1);

        applyStimulus(5, 3, 2, 3, 1'b1);
        runTrain("inverted", 5, 3, 2, 3, 1'b1, -1, 0, 0, -1, -1);

        applyStimulus(4, 0, 2, 2, 1'b0);
        runTrain("zeroCount", 4, 0, 2, 2, 1'b0, -1, 0, 0, -1, -1);

        applyStimulus(2, 4, 2, 2, 1'b1);
        runTrain("abort", 2, 4, 2, 2, 1'b1, -1, 0, 0, -1, 9);
        runTrain("afterAbort", 2, 4, 2, 2, 1'b1, -1, 0, 0, -1, -1);

        applyStimulus(6, 2, 3, 2, 1'b0);
        runTrain("shadow", 6, 2, 3, 2, 1'b0, 3, 2, 4, -1, -1);
        runTrain("newConfig", 2, 4, 3, 2, 1'b0, -1, 0, 0, -1, -1);

        applyStimulus(3, 3, 2, 4, 1'b1);
        runTrain("freeze", 3, 3, 2, 4, 1'b1, -1, 0, 0, 7, -1);

        applyStimulus(0, 2, 0, 0, 1'b0);
        runTrain("minimal", 0, 2, 0, 0, 1'b0, -1, 0, 0, -1, -1);

        applyStimulus(1, 2, 1, 1, 1'b0);
        endA = trainEnd(1, 2, 1, 1);
        trigger = 1'b1;
        tick();
        for (int o = 0; o <= endA; o++) begin
            if (o > 0) tick();
            checkCycle($sformatf("heldA@%0d", o), model(1, 2, 1, 1, 1'b0, o));
        end
        tick();
        trigger = 1'b0;
        endB = trainEnd(1, 2, 1, 1) + 1;
        for (int o = 0; o <= endB; o++) begin
            if (o > 0) tick();
            checkCycle($sformatf("heldB@%0d", o), model(1, 2, 1, 1, 1'b0, o));
        end

        applyStimulus(2, 3, 4, 1, 1'b1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int o = 1; o <= 4; o++) tick();
        checkOutput("preReset.out", int'(outputSignal), 0);
        resetN = 1'b0;
        #1;
        checkOutput("midReset.out", int'(outputSignal), 0);
        checkOutput("midReset.busy", int'(busy), 0);
        checkOutput("midReset.done", int'(done), 0);
        #1;
        resetN = 1'b1;
        tick();
        checkOutput("postReset.out", int'(outputSignal), 0);
        checkOutput("postReset.busy", int'(busy), 0);

        for (int i = 0; i < 12; i++) begin
            d = int'($urandom_range(0, 12));
            n = int'($urandom_range(0, 5));
            h = int'($urandom_range(0, 4));
            l = int'($urandom_range(0, 4));
            p = 1'($urandom_range(0, 1));
            applyStimulus(d, n, h, l, p);
            runTrain($sformatf("rand%0d", i), d, n, h, l, p, -1, 0, 0, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
